control_pipe: RTL and testbench
===============================

CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, using the codebase port names clk and rst.
REQ-002 The block SHALL have these parameters:
- OPW, default 4: opcode width; opcodes at or above 16 decode as NOP.
- REGW, default 4: register-address width.
- ALUW, default 6: width of the ALU control field.
- MUL_LAT, default 2: MUL issue occupancy in cycles; legal range 1..15.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  decoder accepts the offered instruction this cycle.
- opcode  in  OPW  instruction opcode.
- cmp_flag  in  2  compare mode: 0 NOP, 1 LT, 2 EQ, 3 LE.
- rs_a, rs_b, rd  in  REGW each  source and destination register addresses.
- flush  in  1  squash request from the branch unit.
- out_valid  out  1  registered control bundle is valid.
- alu_ctrl  out  ALUW  ALU operation code.
- sel_b  out  2  ALU B-operand select.
- mem_we, mem_re, sel_data_out, reg_we, re_a, re_b, cmp_en, branch, alu_mux  out  1 each  control strobes.
- out_rd  out  REGW  registered copy of rd.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-004 alu_ctrl SHALL decode as follows:
- opcodes 0-7 map to alu_ctrl equal to the opcode.
- opcode 8 maps by cmp_flag: 1 to 8, 2 to 9, 3 to 10, 0 to 63.
- opcode 9 maps to 11, and opcode 10 maps to 12.
- opcodes 12 and 13 map to 0.
- all other opcodes map to 14.
REQ-005 sel_b SHALL be 1 for opcode 12, 2 for opcode 13, 3 for opcode 15, and 0 otherwise.
REQ-006 The memory and write-back strobes SHALL decode as follows:
- mem_re and sel_data_out are 1 only for opcode 12.
- mem_we is 1 only for opcode 13.
REQ-007 The register-file strobes SHALL decode as follows:
- re_a is 0 only for opcodes 11, 14 and 15.
- re_b is 0 only for opcodes 6, 11, 12, 14 and 15.
- reg_we is 0 only for opcodes 8, 13, 14 and 15.
REQ-008 The remaining strobes SHALL decode as follows:
- cmp_en is 1 only for opcode 8.
- branch is 1 only for opcode 14.
- alu_mux is 1 only for opcodes 11 and 15.
REQ-009 The block SHALL accept an instruction when in_valid and in_ready are both 1, and its decoded bundle SHALL appear registered on the next cycle with out_valid=1 (latency 1).
REQ-010 In any cycle with no accept, the next cycle SHALL present a bubble: out_valid=0, alu_ctrl=14, sel_b=0, out_rd=0, and all 1-bit strobes 0.
REQ-011 A load-use hazard SHALL exist when all of the following hold: out_valid=1, the registered bundle is a load (mem_re=1), and the incoming instruction's re_a=1 with rs_a==out_rd or its re_b=1 with rs_b==out_rd.
REQ-012 While a load-use hazard exists, in_ready SHALL be 0, so exactly one bubble is inserted.
REQ-013 The FSM SHALL have states RUN and MUL_WAIT, with these transitions:
- Accepting opcode 2 with MUL_LAT>1 sets the occupancy counter to MUL_LAT-1 and moves RUN to MUL_WAIT.
- In MUL_WAIT, in_ready=0 and the counter decrements each cycle.
- When the counter reaches 0, MUL_WAIT returns to RUN; the next accept is possible in that RUN cycle.
REQ-014 With MUL_LAT=1, a MUL SHALL behave like any other opcode and SHALL NOT enter MUL_WAIT.
REQ-015 The flush input SHALL act as follows:
- flush=1 forces in_ready=0 in the same cycle.
- The next cycle is a bubble.
- The FSM returns to RUN and the counter clears.
- flush has priority over the hazard, MUL_WAIT and accept conditions.
REQ-016 in_ready SHALL be computed as (state==RUN) AND no hazard AND flush=0 AND rst=0.
REQ-017 stall_cnt SHALL increment by 1 in each cycle where in_valid=1 and in_ready=0, and SHALL saturate at 65535.
REQ-018 A cycle where in_valid=0 SHALL NOT be counted as a stall, even if in_ready=0.

Reset
REQ-019 While rst=1 at a clk edge, the block SHALL load: out_valid=0, the bubble bundle, state RUN, counter 0 and stall_cnt 0.
REQ-020 in_ready SHALL be 0 during every rst=1 cycle, and reset SHALL take priority over flush and any in-progress MUL_WAIT.

Verification
REQ-021 The bench SHALL cover each of these directed scenarios:
- Decode sweep: opcodes 0-15 with cmp_flag 0-3, in_valid=1 continuously, then a gap cycle -> each bundle matches REQ-004 to REQ-008 one cycle later, and the gap cycle produces a bubble.
- Load-use hazard: LD rd=3, then ADD rs_a=3 -> in_ready=0 for one cycle, one bubble, ADD issued 2 cycles after LD, stall_cnt=1.
- No false hazard: LD rd=3, then NOT rs_b=3 (re_b=0) -> no stall, back-to-back issue.
- MUL occupancy: MUL_LAT=4, MUL then ADD held valid -> in_ready low 3 cycles, ADD out_valid exactly 4 cycles after MUL, stall_cnt=3.
- Flush during MUL_WAIT: flush asserted in the 2nd wait cycle -> next cycle bubble, state RUN, accept resumes the cycle after flush deasserts.
- Mid-operation reset: rst during MUL_WAIT -> next cycle out_valid=0, stall_cnt=0, state RUN; the first accept occurs the cycle after rst falls.

Source files
------------

// File: rtl/control_pipe.sv
// Single-issue decode stage: turns an opcode into a registered control bundle.
// It also stalls on load-use hazards and while a multi-cycle MUL is in flight.
module control_pipe #(
  parameter int OPW     = 4,
  parameter int REGW    = 4,
  parameter int ALUW    = 6,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  opcode,
  input  logic [1:0]      cmp_flag,
  input  logic [REGW-1:0] rs_a,
  input  logic [REGW-1:0] rs_b,
  input  logic [REGW-1:0] rd,
  input  logic            flush,
  output logic            out_valid,
  output logic [ALUW-1:0] alu_ctrl,
  output logic [1:0]      sel_b,
  output logic            mem_we,
  output logic            mem_re,
  output logic            sel_data_out,
  output logic            reg_we,
  output logic            re_a,
  output logic            re_b,
  output logic            cmp_en,
  output logic            branch,
  output logic            alu_mux,
  output logic [REGW-1:0] out_rd,
  output logic [15:0]     stall_cnt
);

  typedef struct packed {
    logic [ALUW-1:0] alu;
    logic [1:0]      sel_b;
    logic            mem_we;
    logic            mem_re;
    logic            sel_data_out;
    logic            reg_we;
    logic            re_a;
    logic            re_b;
    logic            cmp_en;
    logic            branch;
    logic            alu_mux;
  } bundle_t;

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam bundle_t BUBBLE = '{alu: ALUW'(14), sel_b: 2'd0, default: 1'b0};

  function automatic bundle_t decode(input logic [3:0] op, input logic [1:0] cf, input logic wide);
    bundle_t b;
    b = BUBBLE;
    if (!wide) begin
      b.alu    = ALUW'(op);
      b.re_a   = 1'b1;
      b.re_b   = 1'b1;
      b.reg_we = 1'b1;
      case (op)
        4'd6:  b.re_b = 1'b0;
        4'd8: begin
          case (cf)
            2'd1:    b.alu = ALUW'(8);
            2'd2:    b.alu = ALUW'(9);
            2'd3:    b.alu = ALUW'(10);
            default: b.alu = ALUW'(63);
          endcase
          b.reg_we = 1'b0;
          b.cmp_en = 1'b1;
        end
        4'd9:  b.alu = ALUW'(11);
        4'd10: b.alu = ALUW'(12);
        4'd11: begin
          b.alu     = ALUW'(14);
          b.re_a    = 1'b0;
          b.re_b    = 1'b0;
          b.alu_mux = 1'b1;
        end
        4'd12: begin
          b.alu          = '0;
          b.sel_b        = 2'd1;
          b.mem_re       = 1'b1;
          b.sel_data_out = 1'b1;
          b.re_b         = 1'b0;
        end
        4'd13: begin
          b.alu    = '0;
          b.sel_b  = 2'd2;
          b.mem_we = 1'b1;
          b.reg_we = 1'b0;
        end
        4'd14: begin
          b.alu    = ALUW'(14);
          b.re_a   = 1'b0;
          b.re_b   = 1'b0;
          b.reg_we = 1'b0;
          b.branch = 1'b1;
        end
        4'd15: begin
          b.alu     = ALUW'(14);
          b.sel_b   = 2'd3;
          b.re_a    = 1'b0;
          b.re_b    = 1'b0;
          b.reg_we  = 1'b0;
          b.alu_mux = 1'b1;
        end
        default: ;
      endcase
    end
    return b;
  endfunction

  // Opcodes with any bit above bit 3 set fall outside the table and decode as NOP.
  logic wide_op;
  generate
    if (OPW > 4) begin : g_wide
      assign wide_op = |opcode[OPW-1:4];
    end else begin : g_narrow
      assign wide_op = 1'b0;
    end
  endgenerate

  bundle_t dec_p0, bun_p1;
  state_t  state;
  logic [3:0] cnt;
  logic hazard, accept, is_mul;

  assign dec_p0 = decode(opcode[3:0], cmp_flag, wide_op);
  assign hazard = out_valid && bun_p1.mem_re &&
                  ((dec_p0.re_a && rs_a == out_rd) || (dec_p0.re_b && rs_b == out_rd));
  assign in_ready = (state == RUN) && !hazard && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign is_mul   = !wide_op && opcode[3:0] == 4'd2;

  // ---- stage p1: registered control bundle, FSM and stall counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bun_p1    <= BUBBLE;
      out_rd    <= '0;
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      out_valid <= accept;
      bun_p1    <= accept ? dec_p0 : BUBBLE;
      out_rd    <= accept ? rd : '0;
      if (flush) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        case (state)
          RUN: if (accept && is_mul && MUL_LAT > 1) begin
            state <= MUL_WAIT;
            cnt   <= 4'(MUL_LAT - 1);
          end
          MUL_WAIT: if (cnt <= 4'd1) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  assign alu_ctrl     = bun_p1.alu;
  assign sel_b        = bun_p1.sel_b;
  assign mem_we       = bun_p1.mem_we;
  assign mem_re       = bun_p1.mem_re;
  assign sel_data_out = bun_p1.sel_data_out;
  assign reg_we       = bun_p1.reg_we;
  assign re_a         = bun_p1.re_a;
  assign re_b         = bun_p1.re_b;
  assign cmp_en       = bun_p1.cmp_en;
  assign branch       = bun_p1.branch;
  assign alu_mux      = bun_p1.alu_mux;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode sweep, hazards, MUL occupancy, flush, reset.
module tb_control_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush;
  logic [3:0] opcode, rs_a, rs_b, rd, out_rd;
  logic [1:0] cmp_flag, sel_b;
  logic out_valid, mem_we, mem_re, sel_data_out, reg_we, re_a, re_b, cmp_en, branch, alu_mux;
  logic [5:0] alu_ctrl;
  logic [15:0] stall_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  control_pipe #(.OPW(4), .REGW(4), .ALUW(6), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .cmp_flag(cmp_flag), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .flush(flush),
    .out_valid(out_valid), .alu_ctrl(alu_ctrl), .sel_b(sel_b), .mem_we(mem_we),
    .mem_re(mem_re), .sel_data_out(sel_data_out), .reg_we(reg_we), .re_a(re_a),
    .re_b(re_b), .cmp_en(cmp_en), .branch(branch), .alu_mux(alu_mux),
    .out_rd(out_rd), .stall_cnt(stall_cnt)
  );

  // Hand-derived decode tables; strobes are {mem_we,mem_re,sel_data_out,reg_we,re_a,re_b,cmp_en,branch,alu_mux}.
  localparam logic [5:0] ALU_T [16] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                       6'd0, 6'd11, 6'd12, 6'd14, 6'd0, 6'd0, 6'd14, 6'd14};
  localparam logic [5:0] CMP_T [4] = '{6'd63, 6'd8, 6'd9, 6'd10};
  localparam logic [1:0] SELB_T [16] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                        2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
  localparam logic [8:0] STB_T [16] = '{
    9'b000_111_000, 9'b000_111_000, 9'b000_111_000, 9'b000_111_000,
    9'b000_111_000, 9'b000_111_000, 9'b000_110_000, 9'b000_111_000,
    9'b000_011_100, 9'b000_111_000, 9'b000_111_000, 9'b000_100_001,
    9'b011_110_000, 9'b100_011_000, 9'b000_000_010, 9'b000_000_001};
  localparam logic [21:0] BUB = {1'b0, 6'd14, 2'd0, 9'd0, 4'd0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] expv(input int op, input int cf, input int d);
    logic [5:0] a;
    a = (op == 8) ? CMP_T[cf] : ALU_T[op];
    return {1'b1, a, SELB_T[op], STB_T[op], 4'(d)};
  endfunction

  function automatic logic [21:0] obs();
    return {out_valid, alu_ctrl, sel_b, mem_we, mem_re, sel_data_out, reg_we,
            re_a, re_b, cmp_en, branch, alu_mux, out_rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int cf, input int a, input int b, input int d, input logic v);
    opcode = 4'(op); cmp_flag = 2'(cf); rs_a = 4'(a); rs_b = 4'(b); rd = 4'(d); in_valid = v;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0;
    drive(1, 0, 0, 0, 5, 1'b1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst_bundle", 32'(obs()), 32'(BUB));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    #1;

    // Decode sweep: each instruction held until accepted, bundle checked one cycle later.
    for (int op = 0; op < 16; op++) begin
      for (int cf = 0; cf < 4; cf++) begin
        drive(op, cf, 5, 6, op, 1'b1);
        n = 0;
        while (!in_ready && n < 20) begin
          step();
          n++;
        end
        chk("sweep_wait", 32'(n < 20), 32'd1);
        step();
        chk($sformatf("sweep_op%0d_cf%0d", op, cf), 32'(obs()), 32'(expv(op, cf, op)));
      end
    end
    drive(0, 0, 0, 0, 0, 1'b0);
    step();
    chk("sweep_gap", 32'(obs()), 32'(BUB));

    // Load-use hazard
    do_reset();
    drive(12, 0, 0, 0, 3, 1'b1);
    chk("lu_ld_ready", 32'(in_ready), 32'd1);
    step();
    chk("lu_ld_out", 32'(obs()), 32'(expv(12, 0, 3)));
    drive(0, 0, 3, 0, 7, 1'b1);
    chk("lu_stall", 32'(in_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(obs()), 32'(BUB));
    chk("lu_resume", 32'(in_ready), 32'd1);
    step();
    chk("lu_add_out", 32'(obs()), 32'(expv(0, 0, 7)));
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // No false hazard: op 6 does not read rs_b
    do_reset();
    drive(12, 0, 0, 0, 3, 1'b1);
    step();
    drive(6, 0, 0, 3, 8, 1'b1);
    chk("nf_ready", 32'(in_ready), 32'd1);
    step();
    chk("nf_out", 32'(obs()), 32'(expv(6, 0, 8)));
    chk("nf_stall_cnt", 32'(stall_cnt), 32'd0);

    // MUL occupancy with MUL_LAT=4
    do_reset();
    drive(2, 0, 1, 1, 4, 1'b1);
    step();
    chk("mul_out", 32'(obs()), 32'(expv(2, 0, 4)));
    drive(0, 0, 1, 2, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mul_wait%0d", i), 32'(in_ready), 32'd0);
      step();
    end
    chk("mul_resume", 32'(in_ready), 32'd1);
    step();
    chk("mul_add_out", 32'(obs()), 32'(expv(0, 0, 5)));
    chk("mul_stall_cnt", 32'(stall_cnt), 32'd3);

    // Flush in the second MUL_WAIT cycle; idle first wait cycle is not a stall
    do_reset();
    drive(2, 0, 1, 1, 4, 1'b1);
    step();
    drive(0, 0, 0, 0, 0, 1'b0);
    chk("fl_wait1", 32'(in_ready), 32'd0);
    step();
    flush = 1'b1;
    drive(0, 0, 1, 2, 9, 1'b1);
    chk("fl_ready_low", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_bubble", 32'(obs()), 32'(BUB));
    chk("fl_resume", 32'(in_ready), 32'd1);
    chk("fl_stall_cnt", 32'(stall_cnt), 32'd1);
    step();
    chk("fl_add_out", 32'(obs()), 32'(expv(0, 0, 9)));

    // Reset in the middle of MUL_WAIT
    do_reset();
    drive(2, 0, 1, 1, 4, 1'b1);
    step();
    drive(0, 0, 1, 2, 10, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("mr_ready_low", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mr_bubble", 32'(obs()), 32'(BUB));
    chk("mr_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("mr_resume", 32'(in_ready), 32'd1);
    step();
    chk("mr_add_out", 32'(obs()), 32'(expv(0, 0, 10)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
